// File: rtl/wrr_arb_pkg.sv
// Shared constants and helpers for the weighted round-robin arbiter.
package wrr_arb_pkg;

  localparam int unsigned DEFAULT_N_REQ    = 4;
  localparam int unsigned DEFAULT_WEIGHT_W = 4;
  localparam int unsigned MAX_N_REQ        = 32;
  localparam int unsigned MAX_IDX_W        = 5;

  // Convert a one-hot (or zero) vector to its bit index; zero maps to 0.
  function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_N_REQ-1:0] oh);
    logic [MAX_IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(MAX_N_REQ); i++) begin
      if (oh[i]) r = r | MAX_IDX_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/wrr_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first set request at or after start, wrapping.
module rr_pick
  import wrr_arb_pkg::*;
#(
  parameter int unsigned N_REQ = DEFAULT_N_REQ
) (
  input  logic [N_REQ-1:0]         request,
  input  logic [$clog2(N_REQ)-1:0] start,
  output logic [N_REQ-1:0]         winner,
  output logic [$clog2(N_REQ)-1:0] idx,
  output logic                     found
);

  localparam int unsigned IDW = $clog2(N_REQ);

  int unsigned pos;

  // Scan N_REQ positions beginning at start; the first asserted request wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    pos    = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      pos = 32'(start) + k;
      if (pos >= N_REQ) pos = pos - N_REQ;
      if (!found && request[IDW'(pos)]) begin
        winner[IDW'(pos)] = 1'b1;
        found             = 1'b1;
      end
    end
  end

  assign idx = IDW'(onehot_to_idx(MAX_N_REQ'(winner)));

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter with per-requester quantum and grant lock.
module wrr_arbiter
  import wrr_arb_pkg::*;
#(
  parameter int unsigned N_REQ    = DEFAULT_N_REQ,
  parameter int unsigned WEIGHT_W = DEFAULT_WEIGHT_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          request,
  input  logic [N_REQ*WEIGHT_W-1:0] weight,
  input  logic                      lock,
  output logic [N_REQ-1:0]          grant,
  output logic [$clog2(N_REQ)-1:0]  grant_id,
  output logic                      grant_valid
);

  localparam int unsigned IDW = $clog2(N_REQ);

  logic [WEIGHT_W-1:0] count_q, count_d;
  logic [IDW-1:0]      last_ptr_q, last_ptr_d;
  logic [N_REQ-1:0]    grant_d;
  logic [IDW-1:0]      grant_id_d;
  logic                grant_valid_d;

  logic [IDW-1:0]      start_ptr;
  logic [N_REQ-1:0]    pick_oh;
  logic [IDW-1:0]      pick_idx;
  logic                pick_found;

  logic [WEIGHT_W-1:0] weight_arr [N_REQ];
  logic [WEIGHT_W-1:0] pick_quantum;
  logic                beat;
  logic                expire;
  logic                arbitrate;

  // Unpack the flat weight bus into one field per requester.
  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      weight_arr[i] = weight[i*WEIGHT_W +: WEIGHT_W];
    end
  end

  // Search begins one past the last winner, wrapping at N_REQ.
  assign start_ptr = (last_ptr_q == IDW'(N_REQ - 1)) ? '0 : last_ptr_q + IDW'(1);

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .request (request),
    .start   (start_ptr),
    .winner  (pick_oh),
    .idx     (pick_idx),
    .found   (pick_found)
  );

  // Beat / expiry / arbitration decision; a zero weight still grants one beat.
  always_comb begin
    beat         = grant_valid && request[grant_id];
    expire       = beat && (count_q == WEIGHT_W'(1)) && !lock;
    arbitrate    = (!grant_valid && (|request)) || (grant_valid && !beat) || expire;
    pick_quantum = (weight_arr[pick_idx] == '0) ? WEIGHT_W'(1) : weight_arr[pick_idx];
  end

  // Next-state: re-arbitrate, or count down the holder's quantum (saturating at 1 under lock).
  always_comb begin
    grant_d       = grant;
    grant_id_d    = grant_id;
    grant_valid_d = grant_valid;
    count_d       = count_q;
    last_ptr_d    = last_ptr_q;
    if (arbitrate) begin
      if (pick_found) begin
        grant_d       = pick_oh;
        grant_id_d    = pick_idx;
        grant_valid_d = 1'b1;
        count_d       = pick_quantum;
        last_ptr_d    = pick_idx;
      end else begin
        grant_d       = '0;
        grant_id_d    = '0;
        grant_valid_d = 1'b0;
        count_d       = '0;
      end
    end else if (beat && (count_q > WEIGHT_W'(1))) begin
      count_d = count_q - WEIGHT_W'(1);
    end
  end

  // State registers with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant       <= '0;
      grant_id    <= '0;
      grant_valid <= 1'b0;
      count_q     <= '0;
      last_ptr_q  <= IDW'(N_REQ - 1);
    end else begin
      grant       <= grant_d;
      grant_id    <= grant_id_d;
      grant_valid <= grant_valid_d;
      count_q     <= count_d;
      last_ptr_q  <= last_ptr_d;
    end
  end

endmodule

// File: tb/tb_wrr_arbiter.sv
// Directed self-checking bench for wrr_arbiter (N_REQ=4, WEIGHT_W=4).
module tb_wrr_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  request;
  logic [15:0] weight;
  logic        lock;
  logic [3:0]  grant;
  logic [1:0]  grant_id;
  logic        grant_valid;

  int n_asserts = 0;
  int n_fail    = 0;

  wrr_arbiter #(.N_REQ(4), .WEIGHT_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .request     (request),
    .weight      (weight),
    .lock        (lock),
    .grant       (grant),
    .grant_id    (grant_id),
    .grant_valid (grant_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  // Compare grant, grant_id and grant_valid against the expected one-hot grant.
  task automatic check(input string tag, input logic [3:0] eg);
    logic [1:0] eid;
    logic       ev;
    eid = 2'd0;
    for (int i = 0; i < 4; i++) if (eg[i]) eid = 2'(i);
    ev = (eg != 4'b0000);
    n_asserts++;
    assert (grant === eg) else begin
      n_fail++;
      $error("FAIL %s grant=%b expected %b", tag, grant, eg);
    end
    n_asserts++;
    assert (grant_id === eid) else begin
      n_fail++;
      $error("FAIL %s grant_id=%0d expected %0d", tag, grant_id, eid);
    end
    n_asserts++;
    assert (grant_valid === ev) else begin
      n_fail++;
      $error("FAIL %s grant_valid=%b expected %b", tag, grant_valid, ev);
    end
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    request = 4'b0000;
    lock    = 1'b0;
    tick();
    check("reset", 4'b0000);
    reset = 1'b0;
  endtask

  logic [3:0] exp_rr   [5];
  logic [3:0] exp_wt   [8];
  logic [3:0] exp_zero [4];

  initial begin
    exp_rr   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_wt   = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0001, 4'b0001, 4'b0001};
    exp_zero = '{4'b0001, 4'b0010, 4'b0001, 4'b0010};

    reset   = 1'b1;
    request = 4'b0000;
    weight  = 16'h0000;
    lock    = 1'b0;
    tick();
    tick();
    check("reset_state", 4'b0000);

    // Idle with no request stays idle.
    reset = 1'b0;
    tick();
    check("idle_norq", 4'b0000);

    // All four requesting, unit weights: plain round robin starting at 0.
    do_reset();
    request = 4'b1111;
    weight  = 16'h1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("rr_%0d", i), exp_rr[i]);
    end

    // Weights 3 and 2 on requesters 0 and 1.
    do_reset();
    request = 4'b0011;
    weight  = 16'h0023;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("wt_%0d", i), exp_wt[i]);
    end

    // Zero weights behave as one beat each.
    do_reset();
    request = 4'b0011;
    weight  = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("w0_%0d", i), exp_zero[i]);
    end

    // Sole requester keeps the grant across quantum boundaries.
    do_reset();
    request = 4'b0001;
    weight  = 16'h0002;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("sole_%0d", i), 4'b0001);
    end

    // Holder 2 drops after one beat; then holder 1 drops with nobody else.
    do_reset();
    request = 4'b0100;
    weight  = 16'h0400;
    tick();
    check("drop_grant2", 4'b0100);
    request = 4'b0110;
    tick();
    check("drop_beat", 4'b0100);
    request = 4'b0010;
    tick();
    check("drop_to1", 4'b0010);
    request = 4'b0000;
    tick();
    check("drop_none", 4'b0000);

    // Lock holds requester 1 past its unit quantum; release moves to 2.
    do_reset();
    request = 4'b0010;
    weight  = 16'h1111;
    tick();
    check("lock_grant1", 4'b0010);
    lock    = 1'b1;
    request = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("lock_%0d", i), 4'b0010);
    end
    lock = 1'b0;
    tick();
    check("unlock", 4'b0100);

    // Reset mid-quantum clears outputs; next grant goes to requester 3.
    do_reset();
    request = 4'b0011;
    weight  = 16'h0003;
    tick();
    check("mid_grant0", 4'b0001);
    tick();
    check("mid_hold", 4'b0001);
    reset = 1'b1;
    tick();
    check("mid_reset", 4'b0000);
    reset   = 1'b0;
    request = 4'b1000;
    tick();
    check("post_reset3", 4'b1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/wrr_arbiter.md
WRR_ARBITER -- requirements
Module: wrr_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, SHALL set the requester count; legal range 2..32.
REQ-002 Parameter WEIGHT_W, default 4, SHALL set the per-requester weight field width; legal range 1..8.
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  SHALL be the synchronous, active-high reset.
REQ-005 Port request  input  N_REQ  SHALL carry one request bit per requester, level-sensitive.
REQ-006 Port weight  input  N_REQ*WEIGHT_W  SHALL carry per-requester quantum; field i = bits [i*WEIGHT_W +: WEIGHT_W].
REQ-007 Port lock  input  1  SHALL, while high, extend the current grant beyond its quantum.
REQ-008 Port grant  output  N_REQ  SHALL be registered, one-hot or zero.
REQ-009 Port grant_id  output  $clog2(N_REQ)  SHALL be the registered index of the granted requester; 0 when grant is zero.
REQ-010 Port grant_valid  output  1  SHALL be registered, high iff grant is non-zero.

Function
REQ-011 Beat: any cycle with grant[g]=1 and request[g]=1; each beat SHALL decrement the quantum counter by 1.
REQ-012 On a new grant to requester i, quantum counter SHALL load weight[i]; weight 0 SHALL be treated as 1; weight changes while granted SHALL NOT affect the current quantum.
REQ-013 Arbitration SHALL occur in cycle C when: idle (grant=0) with request non-zero; holder drops request; or a beat occurs with counter=1 and lock=0. New grant SHALL appear at edge C+1 (1-cycle latency).
REQ-014 Search order SHALL start at last_ptr+1 and wrap modulo N_REQ; first requester with request=1 wins; last_ptr SHALL update to the winner.
REQ-015 On quantum expiry, holder SHALL be re-granted (fresh quantum) only if it is the sole requester.
REQ-016 With lock=1, quantum expiry SHALL NOT release the grant; counter SHALL saturate at 1; dropping request still releases.
REQ-017 If holder drops request and no other request is high, grant SHALL go to zero at next edge.
REQ-018 A grant SHALL never be issued to a requester whose request bit is low in the deciding cycle.
REQ-019 Requests arriving while grant held SHALL wait; no requester with continuous request SHALL wait more than N_REQ-1 quanta (lock=0).
REQ-020 Simultaneous holder-release and new requests SHALL resolve in one cycle with no idle gap.

Reset
REQ-021 While reset=1: grant=0, grant_id=0, grant_valid=0, counter=0, last_ptr=N_REQ-1 (first search starts at requester 0).
REQ-022 Reset mid-grant SHALL drop grant at the next edge; reset SHALL take priority over all inputs.

Structure
REQ-023 Package wrr_arb_pkg SHALL hold default parameter constants and a function for the one-hot-to-index conversion.
REQ-024 Sub-module rr_pick (combinational rotating-priority picker: request, start pointer -> one-hot winner, index, found) SHALL be used; all state lives in wrr_arbiter.

Verification
REQ-025 Reset, request=4'b1111, all weights 1 -> grants 0,1,2,3,0 on consecutive cycles starting 1 cycle after first request.
REQ-026 request=4'b0011, weight0=3, weight1=2, lock=0 -> grant pattern 0,0,0,1,1,0,0,0,...
REQ-027 request=4'b0001 only, weight0=2 -> grant stays on 0 continuously, grant_valid never drops.
REQ-028 Holder 2 (weight 4) drops request after 1 beat while request1=1 -> grant moves to 1 next edge; drop with no others -> grant=0 next edge.
REQ-029 lock=1 with holder 1 weight 1 and request=4'b1111 for 5 cycles -> grant stays 1; lock=0 -> grant moves to 2 after next beat.
REQ-030 Reset asserted mid-quantum -> all outputs 0 at next edge; after release with request=4'b1000 -> grant=4'b1000.
